// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencer that initialises the 8-channel PWM peripheral
// (periods, then enable mask) and, once per ramp tick, slews each channel's
// duty register toward its host target by at most `step` per tick.
// `reset` is asynchronous and active-low.
module pwm_ramp_ctrl #(
    parameter int          PERIOD   = 255,
    parameter int          TICK_DIV = 1000,
    parameter logic [7:0]  EN_MASK  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tgt_we,
    input  logic [2:0]  tgt_ch,
    input  logic [15:0] tgt_val,
    input  logic [15:0] step,
    input  logic        hold,
    output logic [15:0] m_addr,
    output logic [31:0] m_datain,
    output logic        m_w,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {INIT_PER, INIT_EN, IDLE, SCAN} state_t;

    localparam int          CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] PERIOD_W = 16'(PERIOD);

    state_t          state_reg;
    logic [2:0]      ch_reg;
    logic            pend_reg;
    logic [CW-1:0]   tick_cnt_reg;
    logic            tick;
    logic [15:0]     cur_reg [8];
    logic [15:0]     tgt_reg [8];
    logic [7:0]      ch_eq;
    logic            all_eq;
    logic [15:0]     cur_sel;
    logic [15:0]     tgt_sel;
    logic [15:0]     diff;
    logic [15:0]     ramp_next;

    assign tick = (tick_cnt_reg == CW'(TICK_DIV - 1));

    // Free-running tick divider, counting from reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt_reg <= '0;
        else if (tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + CW'(1);
    end

    // Host target registers; writable in every state. A write landing on the
    // channel being scanned is seen by that scan only on the next tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++)
                tgt_reg[i] <= '0;
        end else if (tgt_we) begin
            tgt_reg[tgt_ch] <= tgt_val;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_eq
            assign ch_eq[gi] = (cur_reg[gi] == tgt_reg[gi]);
        end
    endgenerate

    assign all_eq = &ch_eq;

    // Bounded slew of the channel under scan, never wrapping past the target.
    always_comb begin
        cur_sel   = cur_reg[ch_reg];
        tgt_sel   = tgt_reg[ch_reg];
        diff      = (cur_sel < tgt_sel) ? (tgt_sel - cur_sel) : (cur_sel - tgt_sel);
        ramp_next = tgt_sel;
        if (step != 16'd0 && diff > step) begin
            if (cur_sel < tgt_sel)
                ramp_next = cur_sel + step;
            else
                ramp_next = cur_sel - step;
        end
    end

    // Sequencer: init writes, idle/scan handshake with the tick flag, and all
    // registered bus/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= INIT_PER;
            ch_reg    <= '0;
            pend_reg  <= 1'b0;
            m_w       <= 1'b0;
            m_addr    <= '0;
            m_datain  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 8; i++)
                cur_reg[i] <= '0;
        end else begin
            m_w <= 1'b0;
            if (tick)
                pend_reg <= 1'b1;
            case (state_reg)
                INIT_PER: begin
                    m_w      <= 1'b1;
                    m_addr   <= 16'd4 + {10'd0, ch_reg, 3'd0};
                    m_datain <= {16'd0, PERIOD_W};
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    ch_reg   <= ch_reg + 3'd1;
                    if (ch_reg == 3'd7)
                        state_reg <= INIT_EN;
                end
                INIT_EN: begin
                    m_w       <= 1'b1;
                    m_addr    <= 16'd0;
                    m_datain  <= {24'd0, EN_MASK};
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                IDLE: begin
                    if (pend_reg && !hold) begin
                        // A tick arriving on the entry edge re-arms the flag.
                        pend_reg  <= tick;
                        ch_reg    <= 3'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state_reg <= SCAN;
                    end else begin
                        busy <= 1'b0;
                        done <= all_eq;
                    end
                end
                SCAN: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    if (cur_sel != tgt_sel) begin
                        cur_reg[ch_reg] <= ramp_next;
                        m_w      <= 1'b1;
                        m_addr   <= 16'd8 + {10'd0, ch_reg, 3'd0};
                        m_datain <= {16'd0, ramp_next};
                    end
                    ch_reg <= ch_reg + 3'd1;
                    if (ch_reg == 3'd7)
                        state_reg <= IDLE;
                end
                default: state_reg <= INIT_PER;
            endcase
        end
    end

endmodule
